// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions: forward-select and drain-FSM encodings,
// counter widths and the operand forwarding priority rule.
package hazard_unit_pkg;

   localparam int REG_W  = 4;
   localparam int CNT_W  = 16;
   localparam int PEND_W = 3;

   // The longest legal PC-write drain is four cycles (a load-use stall plus
   // the D, E and M stages), so a fifth PEND cycle means something is wrong.
   localparam logic [PEND_W-1:0] PEND_ERR = 3'd5;
   localparam logic [PEND_W-1:0] PEND_MAX = 3'd7;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwdSel_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PEND = 2'b01,
      WB   = 2'b10
   } drainState_t;

   // The M stage holds the younger result, so it wins over W.
   function automatic fwdSel_t fwdSelect(
      input logic [REG_W-1:0] ra,
      input logic [REG_W-1:0] waM,
      input logic [REG_W-1:0] waW,
      input logic             wrM,
      input logic             wrW,
      input logic             allow
   );
      if (allow && wrM && (ra == waM)) return FWD_M;
      if (allow && wrW && (ra == waW)) return FWD_W;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle. The pipeline is the master: it
// drives register addresses and stage qualifiers and consumes the
// forward/stall/flush controls and the performance state.
interface hazard_unit_if;
   import hazard_unit_pkg::*;

   logic [REG_W-1:0] RA1D, RA2D;
   logic [REG_W-1:0] RA1E, RA2E;
   logic [REG_W-1:0] WA3E, WA3M, WA3W;
   logic             RegWriteM, RegWriteW;
   logic             MemtoRegE;
   logic             IgRnE;
   logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW;
   logic             BranchTakenE;
   logic             CntClr;

   logic [1:0]       ForwardAE, ForwardBE;
   logic             StallF, StallD;
   logic             FlushD, FlushE;
   logic [CNT_W-1:0] StallCnt, FlushCnt;
   logic             PcwErr;

   modport master (
      output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
      output RegWriteM, RegWriteW, MemtoRegE, IgRnE,
      output PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, CntClr,
      input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
      input  StallCnt, FlushCnt, PcwErr
   );

   modport slave (
      input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
      input  RegWriteM, RegWriteW, MemtoRegE, IgRnE,
      input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, CntClr,
      output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
      output StallCnt, FlushCnt, PcwErr
   );

endinterface

// File: rtl/hazard_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping. Clear beats
// increment; reset beats clear.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] count
);

   // count enabled cycles, holding at the top value
   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, PC-write drain
// control, a watchdog on overlong drains and stall/flush event counters.
//
// Drain FSM
//   state | meaning
//   IDLE  | no PC-writing instruction in D/E/M
//   PEND  | PC write travelling through D/E/M; fetch held
//   WB    | PC write retiring in W this cycle
module hazard_unit
   import hazard_unit_pkg::*;
(
   input logic          clk,
   input logic          reset,
   hazard_unit_if.slave hz
);

   logic              ldStall;
   logic              pcPend;
   logic              stallF, stallD, flushD, flushE;
   fwdSel_t           fwdA, fwdB;
   drainState_t       stateQ, stateNext;
   logic              inPend, enterPend;
   logic [PEND_W-1:0] pendCnt, pendCntNext;
   logic              pcwErr;

   // raw hazard conditions from the current stage contents
   always_comb begin
      ldStall = hz.MemtoRegE & ((hz.RA1D == hz.WA3E) | (hz.RA2D == hz.WA3E));
      pcPend  = hz.PCSrcD | hz.PCSrcE | hz.PCSrcM;
   end

   // forward selects and stall/flush controls; reset holds the pipe flushed
   always_comb begin
      fwdA   = FWD_RF;
      fwdB   = FWD_RF;
      stallF = 1'b0;
      stallD = 1'b0;
      flushD = 1'b1;
      flushE = 1'b1;
      if (reset) begin
         fwdA   = fwdSelect(hz.RA1E, hz.WA3M, hz.WA3W, hz.RegWriteM, hz.RegWriteW, ~hz.IgRnE);
         fwdB   = fwdSelect(hz.RA2E, hz.WA3M, hz.WA3W, hz.RegWriteM, hz.RegWriteW, 1'b1);
         stallF = ldStall | pcPend;
         stallD = ldStall;
         flushD = pcPend | hz.PCSrcW | hz.BranchTakenE;
         flushE = ldStall | hz.BranchTakenE;
      end
   end

   // drive the bundle
   always_comb begin
      hz.ForwardAE = fwdA;
      hz.ForwardBE = fwdB;
      hz.StallF    = stallF;
      hz.StallD    = stallD;
      hz.FlushD    = flushD;
      hz.FlushE    = flushE;
      hz.PcwErr    = pcwErr;
   end

   // drain FSM state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         stateQ <= IDLE;
      end else begin
         stateQ <= stateNext;
      end
   end

   // drain FSM next state; a PEND that ends without PCSrcW was squashed
   always_comb begin
      stateNext = stateQ;
      case (stateQ)
         IDLE:    stateNext = pcPend ? PEND : IDLE;
         PEND: begin
            if (pcPend) begin
               stateNext = PEND;
            end else if (hz.PCSrcW) begin
               stateNext = WB;
            end else begin
               stateNext = IDLE;
            end
         end
         WB:      stateNext = pcPend ? PEND : IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // drain FSM outputs
   always_comb begin
      inPend    = (stateQ == PEND);
      enterPend = (stateNext == PEND);
   end

   // length of the current PEND run, including the cycle about to start
   always_comb begin
      pendCntNext = '0;
      if (enterPend) begin
         if (!inPend) begin
            pendCntNext = 3'd1;
         end else if (pendCnt == PEND_MAX) begin
            pendCntNext = PEND_MAX;
         end else begin
            pendCntNext = pendCnt + 3'd1;
         end
      end
   end

   // PEND run length register
   always_ff @(posedge clk) begin
      if (!reset) begin
         pendCnt <= '0;
      end else if (hz.CntClr) begin
         pendCnt <= '0;
      end else begin
         pendCnt <= pendCntNext;
      end
   end

   // sticky drain-overrun flag, raised on entering the fifth PEND cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         pcwErr <= 1'b0;
      end else if (hz.CntClr) begin
         pcwErr <= 1'b0;
      end else if (pendCntNext == PEND_ERR) begin
         pcwErr <= 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_stallCnt (
      .clk   (clk),
      .reset (reset),
      .en    (stallF),
      .clr   (hz.CntClr),
      .count (hz.StallCnt)
   );

   sat_counter #(.W(CNT_W)) u_flushCnt (
      .clk   (clk),
      .reset (reset),
      .en    (flushE),
      .clr   (hz.CntClr),
      .count (hz.FlushCnt)
   );

endmodule
